// File: rtl/input_event_capture.sv
// input_event_capture: synchronised, debounced buttons/switches with a change-event FIFO.
// Define INPUT_EVENT_TIMESTAMP_EN to tag each event with a 16-bit cycle timestamp.
module input_event_capture #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                         clock_100mhz,
    input  logic                         reset,
    input  logic [4:0]                   buttons_raw,
    input  logic [15:0]                  switches_raw,
    input  logic                         event_pop,
    input  logic                         clear_overflow,
    output logic [4:0]                   button_state,
    output logic [15:0]                  switch_state,
    output logic                         event_valid,
    output logic [5:0]                   event_data,
    output logic [$clog2(FIFO_DEPTH):0]  event_count,
`ifdef INPUT_EVENT_TIMESTAMP_EN
    output logic [15:0]                  event_timestamp,
`endif
    output logic                         overflow
);
    localparam int NI = 21;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef INPUT_EVENT_TIMESTAMP_EN
    localparam int DW = 22;
`else
    localparam int DW = 6;
`endif

    logic [NI-1:0] sync1_q, sync2_q, stable_q, stable_d, pend_q, pend_d, grant;
    logic [CW-1:0] cnt_q [NI];
    logic [CW-1:0] cnt_d [NI];
    logic [4:0]    sel;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d, full, do_push, do_pop, has_pend;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [DW-1:0] wdata, head;
`ifdef INPUT_EVENT_TIMESTAMP_EN
    logic [15:0]   ts_q;
`endif

    always_comb begin
        stable_d = stable_q;
        pend_d   = pend_q & ~grant;
        for (int i = 0; i < NI; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = ~stable_q[i];
                    pend_d[i]   = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // lowest index wins; a bit re-set on its service edge survives via pend_d
    always_comb begin
        sel   = '0;
        grant = '0;
        for (int i = NI - 1; i >= 0; i--)
            if (pend_q[i]) sel = 5'(i);
        grant[sel] = has_pend;
    end

    assign has_pend = |pend_q;
    assign full     = count_q == (AW+1)'(FIFO_DEPTH);
    assign do_pop   = event_pop && event_valid;
    assign do_push  = has_pend && (!full || do_pop);
    assign ovf_d    = (has_pend && full && !do_pop) || (ovf_q && !clear_overflow);
    assign count_d  = (do_push && !do_pop) ? count_q + (AW+1)'(1)
                    : (!do_push && do_pop) ? count_q - (AW+1)'(1) : count_q;
`ifdef INPUT_EVENT_TIMESTAMP_EN
    assign wdata    = {ts_q, sel, stable_q[sel]};
`else
    assign wdata    = {sel, stable_q[sel]};
`endif

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            pend_q   <= '0;
            for (int i = 0; i < NI; i++) cnt_q[i] <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q  <= {switches_raw, buttons_raw};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            for (int i = 0; i < NI; i++) cnt_q[i] <= cnt_d[i];
            wr_q     <= do_push ? wr_q + AW'(1) : wr_q;
            rd_q     <= do_pop ? rd_q + AW'(1) : rd_q;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef INPUT_EVENT_TIMESTAMP_EN
    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) ts_q <= '0;
        else ts_q <= ts_q + 16'd1;
    end
    assign event_timestamp = event_valid ? head[21:6] : '0;
`endif

    // storage needs no reset: outputs are gated by event_valid
    always_ff @(posedge clock_100mhz) begin
        if (do_push) mem[wr_q] <= wdata;
    end

    assign head         = mem[rd_q];
    assign event_valid  = count_q != '0;
    assign event_data   = event_valid ? head[5:0] : '0;
    assign event_count  = count_q;
    assign overflow     = ovf_q;
    assign button_state = stable_q[4:0];
    assign switch_state = stable_q[20:5];
endmodule

// File: tb/tb_input_event_capture.sv
// tb_input_event_capture: scoreboard bench for input_event_capture (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
module tb_input_event_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  buttons_raw = '0;
    logic [15:0] switches_raw = '0;
    logic        event_pop = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [4:0]  button_state;
    logic [15:0] switch_state;
    logic        event_valid;
    logic [5:0]  event_data;
    logic [2:0]  event_count;
    logic        overflow;
    logic [5:0]  exp_q [$];
    int          n_chk = 0;
    int          n_pass = 0;

    input_event_capture #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .clock_100mhz(clk), .reset(reset), .buttons_raw(buttons_raw),
        .switches_raw(switches_raw), .event_pop(event_pop),
        .clear_overflow(clear_overflow), .button_state(button_state),
        .switch_state(switch_state), .event_valid(event_valid),
        .event_data(event_data), .event_count(event_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int id, input logic lvl);
        exp_q.push_back({5'(id), lvl});
    endtask

    // waits (bounded) for a head event, compares it against the scoreboard and pops it
    task automatic drain_one();
        int t = 0;
        while (!event_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!event_valid) chk("ev_timeout", 32'(event_valid), 1);
        else if (exp_q.size() == 0) chk("sb_underflow", 32'(event_data), 32'hffff);
        else begin
            chk("ev_data", 32'(event_data), 32'(exp_q.pop_front()));
            event_pop = 1'b1;
            @(negedge clk);
            event_pop = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        step(3);
        reset = 1'b0;
        step(2);
        chk("rst_count", 32'(event_count), 0);
        chk("rst_valid", 32'(event_valid), 0);

        // two queued events plus one debounce in flight, then reset
        buttons_raw = 5'b00101;
        step(10);
        switches_raw[3] = 1'b1;
        step(3);
        chk("pre_rst_count", 32'(event_count), 2);
        reset = 1'b1;
        buttons_raw = '0;
        switches_raw = '0;
        #1;
        chk("async_rst_count", 32'(event_count), 0);
        step(2);
        chk("rst_bs", 32'(button_state), 0);
        chk("rst_ss", 32'(switch_state), 0);
        chk("rst_valid2", 32'(event_valid), 0);
        chk("rst_data", 32'(event_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        reset = 1'b0;
        step(15);
        chk("post_rst_valid", 32'(event_valid), 0);
        chk("post_rst_bs", 32'(button_state), 0);

        // single button latency
        buttons_raw[1] = 1'b1;
        expect_ev(1, 1'b1);
        step(5);
        chk("bs_early", 32'(button_state), 0);
        step(1);
        chk("bs_edge6", 32'(button_state), 32'h2);
        chk("valid_edge6", 32'(event_valid), 0);
        step(1);
        chk("valid_edge7", 32'(event_valid), 1);
        drain_one();
        chk("valid_after_pop", 32'(event_valid), 0);

        // glitch shorter than the debounce window
        switches_raw[0] = 1'b1;
        step(3);
        switches_raw[0] = 1'b0;
        step(10);
        chk("glitch_ss", 32'(switch_state), 0);
        chk("glitch_count", 32'(event_count), 0);

        // simultaneous changes drain in id order
        buttons_raw[4] = 1'b1;
        switches_raw[15] = 1'b1;
        expect_ev(4, 1'b1);
        expect_ev(20, 1'b1);
        step(7);
        chk("simul_count1", 32'(event_count), 1);
        step(1);
        chk("simul_count2", 32'(event_count), 2);
        drain_one();
        drain_one();

        // six changes into a four-entry FIFO
        switches_raw[6:1] = 6'h3f;
        for (int i = 6; i < 10; i++) expect_ev(i, 1'b1);
        step(15);
        chk("ovf_count", 32'(event_count), 4);
        chk("ovf_set", 32'(overflow), 1);
        clear_overflow = 1'b1;
        step(1);
        clear_overflow = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) drain_one();
        chk("ovf_empty", 32'(event_valid), 0);

        // full FIFO with push and pop on the same edge
        switches_raw[4:1] = 4'h0;
        for (int i = 6; i < 10; i++) expect_ev(i, 1'b0);
        step(15);
        chk("full_count", 32'(event_count), 4);
        switches_raw[5] = 1'b0;
        expect_ev(10, 1'b0);
        step(6);
        chk("full_before", 32'(event_count), 4);
        drain_one();
        chk("full_pushpop_count", 32'(event_count), 4);
        chk("full_pushpop_ovf", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) drain_one();
        chk("final_valid", 32'(event_valid), 0);
        chk("sb_leftover", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/input_event_capture.md
Name: input_event_capture

Overview:
- Input-direction counterpart of the peripheral output path.
- Synchronises and debounces the five push buttons and sixteen slide switches.
- Detects level changes and queues them as events in a small FIFO. The CPU side drains the FIFO with a valid/pop handshake.
- Also exports clean debounced levels for the peripheral status bus.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised input must differ from its stable level before the change is accepted (10 ms at 100 MHz); legal range 1 to 2^24-1.
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.

Ports:
- clock_100mhz  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- buttons_raw  input  5  raw buttons: bit0 center, bit1 up, bit2 right, bit3 down, bit4 left.
- switches_raw  input  16  raw slide switches.
- event_pop  input  1  CPU consumes the head event this cycle; ignored when event_valid is low.
- clear_overflow  input  1  clears the sticky overflow flag.
- button_state  output  5  debounced button levels.
- switch_state  output  16  debounced switch levels.
- event_valid  output  1  FIFO non-empty; head event presented (show-ahead).
- event_data  output  6  head event: [5:1] source id (0-4 buttons in bit order, 5-20 switches 0-15), [0] new level.
- event_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; an event was dropped.

Behaviour:
- Reset: all outputs 0, all internal state cleared. Asynchronous assert, synchronous release via clock edge.
  - Outputs: button_state, switch_state, event_valid, event_data, event_count, overflow.
  - Internal state: synchronisers, debounce counters, pending bits, FIFO pointers.
- Reset mid-operation discards queued events and in-flight debounce counts without generating events.
- Synchronisation: every raw input passes through a two-flop synchroniser. Debounce operates only on synchroniser output.
- Debounce, per input:
  - Counter of width clog2(DEBOUNCE_CYCLES+1).
  - When sync differs from stable, the counter increments. When sync equals stable, the counter clears to 0.
  - When the counter would reach DEBOUNCE_CYCLES, the following happen on that same edge:
    - stable toggles;
    - the counter clears;
    - the input's pending bit sets.
  - A glitch shorter than DEBOUNCE_CYCLES produces no event.
- Latency: stable changes exactly DEBOUNCE_CYCLES+2 edges after the first edge sampling the new raw level. With an empty FIFO and no other pending bit, event_valid asserts on the next edge.
- Arbitration: each cycle the lowest-index pending bit (id 0 highest priority) is pushed, with the current stable level, and its pending bit clears.
  - Simultaneous changes drain one per cycle in id order.
  - A pending bit that sets again before being serviced stays set; the pushed level is always the current stable level.
- FIFO push/pop:
  - Pop with event_valid high removes the head; the next entry appears the following cycle.
  - Push and pop in the same cycle: occupancy unchanged. This is legal even when full.
  - Push when full without pop: event dropped, pending bit still clears, overflow sets.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: held until clear_overflow. If a drop and clear_overflow coincide, overflow stays set.
- event_data is held stable while event_valid is high and no pop occurs.

Optional Feature:
- Macro: INPUT_EVENT_TIMESTAMP_EN.
- Defined:
  - A free-running 16-bit cycle counter, cleared by reset, wraps at 65535 to 0.
  - Its value at the push edge is stored with each event.
  - An extra output event_timestamp (16 bits) presents the head entry's value; it is 0 while event_valid is low.
- Undefined: no counter, no port, FIFO entries are 6 bits.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
- Reset mid-debounce and with 2 queued events -> all outputs 0; no event after release while inputs are steady.
- buttons_raw[1] 0->1 held -> button_state[1]=1 after 6 edges; event_valid next edge with event_data=6'b000011; pop -> event_valid=0.
- switches_raw[0] pulsed high for 3 cycles -> no state change, event_count=0.
- buttons_raw[4] and switches_raw[15] rise on the same edge -> events 6'b001001 then 6'b101001, one cycle apart, in that order.
- Six distinct switch changes with no pops -> event_count=4, overflow=1, first four ids retained; clear_overflow -> overflow=0.
- FIFO full, push and pop in the same cycle -> event_count stays 4, overflow stays 0, new event at the tail.
